seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
- Programmable serial sequence-detector controller for the sequence_detector area.
- Accepts a pattern/length/mode configuration through a valid/ready handshake, arms, and runs a shared shift-window match engine on a qualified bit stream.
- Counts matches and terminates on a target match count or on an inactivity timeout.
- Reports status to a host/sequencer.

Parameters:
- MAXLEN, 8, maximum pattern length in bits.
- LENW, 4, width of cfg_len; must satisfy 2**LENW > MAXLEN.
- CNTW, 8, width of the match counter and the target count.
- TOW, 16, width of the timeout counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accept; combinational from state, high in IDLE and DONE
- cfg_pattern  in  MAXLEN  pattern; bit 0 = most recent bit
- cfg_len  in  LENW  pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_target  in  CNTW  match count that ends a run; 0 = unlimited
- cfg_timeout  in  TOW  cycles without a match that end a run; 0 = disabled
- start  in  1  begin run
- abort  in  1  return to IDLE
- d  in  1  serial data
- d_valid  in  1  d qualifier
- match  out  1  one-cycle pulse per detected match
- match_count  out  CNTW  matches in current/last run
- busy  out  1  state == RUN
- done  out  1  level; run finished
- timed_out  out  1  level; run finished by timeout

Behaviour:
- Reset state:
  - State IDLE; all registers 0.
  - match, busy, done, timed_out, match_count all 0.
  - cfg_ready = 1.
- States: IDLE, ARMED, RUN, DONE.
- Config transfer (cfg_valid && cfg_ready in IDLE or DONE):
  - Latch pattern, len, overlap, target, timeout.
  - Go to ARMED; clear done, timed_out and match_count.
  - cfg_len 0 is latched as 1; cfg_len > MAXLEN is clamped to MAXLEN.
- Start:
  - start in ARMED or DONE → RUN next cycle.
  - Clears window, history count, match_count, timer, done and timed_out.
  - start in IDLE or RUN is ignored.
- RUN, per d_valid cycle:
  - window <= {window[MAXLEN-2:0], d}.
  - hist increments, saturating at MAXLEN.
  - Bits arriving while d_valid = 0 are ignored.
- Match condition:
  - Evaluated on the post-shift window: low len bits of window == low len bits of pattern, and hist >= len.
  - match is a registered pulse in the cycle after the completing d_valid sample.
- On match:
  - match_count increments, saturating at all-ones.
  - Timer clears.
  - overlap = 0: hist resets to 0, so a new match needs len fresh bits.
  - overlap = 1: hist is kept.
- Target reached (target != 0 and count becomes target):
  - → DONE, done = 1, timed_out = 0.
- Timer:
  - Increments every RUN cycle; clears on match and on start.
  - If timeout != 0 and timer reaches timeout-1 with no match in that cycle: → DONE with done = 1, timed_out = 1.
  - A match and a timeout in the same cycle: the match wins (count updates, timer clears, no timeout).
- Priority: abort > config transfer > start.
  - abort in any state → IDLE next cycle.
  - abort clears done, timed_out, match_count, hist and window; a match pulse for that cycle is suppressed.
- DONE:
  - match_count holds.
  - Further d is ignored.
  - Exits only via new config, start (rerun with same config), or abort.
- Reset mid-run: immediate return to reset values; no match pulse.

Decomposition:
- Package seq_det_pkg:
  - state_e enum {IDLE, ARMED, RUN, DONE}.
  - Default MAXLEN/LENW/CNTW/TOW constants.
- Sub-module seq_match_core:
  - Contents: window shift register, hist counter, length-masked compare.
  - Inputs: shift_en, clear, len, pattern.
  - Output: combinational hit.
  - The controller owns the FSM, counters and timer.

Test Plan:
- Overlap off: cfg pattern=0b101, len=3, overlap=0, target=0, timeout=0; start; d_valid bits 1,0,1,0,1 → match pulse exactly once, one cycle after the 3rd bit; match_count=1.
- Overlap on: same stream with overlap=1 → pulses after bits 3 and 5; match_count=2.
- Target stop: pattern=0b11, len=2, overlap=1, target=3; stream of five 1s → pulses after bits 2, 3, 4; done=1, timed_out=0, busy=0; 5th bit ignored; count stays 3.
- Timeout: timeout=10, no matching data → done=1, timed_out=1 exactly 10 cycles after RUN entry; a match in cycle 9 instead restarts the 10-cycle window.
- Gaps and clamping: d_valid gaps inside a pattern still match; cfg_len=0 → behaves as len 1; cfg_len=15 → clamped to 8.
- Handshake and abort:
  - cfg_valid during RUN → cfg_ready=0, no transfer.
  - abort in RUN on the cycle a match completes → IDLE, no pulse, match_count=0.
  - Async reset asserted mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial sequence detector.
//   state_e    : controller states
//   SD_*       : default parameter values for seq_det_ctrl / seq_match_core
package seq_det_pkg;

    localparam int SD_MAXLEN = 8;
    localparam int SD_LENW   = 4;
    localparam int SD_CNTW   = 8;
    localparam int SD_TOW    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/seq_match_core.sv
// Shift-window match engine.
//   clk, reset : clock, asynchronous active-high reset
//   shift_en   : accept d into the window this cycle
//   clear      : zero window and history (wins over shift_en)
//   d          : serial data bit
//   overlap    : 1 = keep history after a hit, 0 = restart history
//   len        : active pattern length (already clamped to 1..MAXLEN)
//   pattern    : pattern, bit 0 = most recent bit
//   hit        : combinational; the window after this shift matches
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAXLEN = SD_MAXLEN,
    parameter int LENW   = SD_LENW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              clear,
    input  logic              d,
    input  logic              overlap,
    input  logic [LENW-1:0]   len,
    input  logic [MAXLEN-1:0] pattern,
    output logic              hit
);

    localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

    logic [MAXLEN-1:0] window_q, window_d;
    logic [LENW-1:0]   hist_q, hist_d;
    logic [MAXLEN-1:0] win_shift;
    logic [MAXLEN-1:0] len_mask;
    logic [LENW-1:0]   hist_inc;

    always_comb begin
        win_shift = {window_q[MAXLEN-2:0], d};
        hist_inc  = (hist_q == MAXLEN_L) ? hist_q : hist_q + LENW'(1);

        len_mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            len_mask[i] = (LENW'(i) < len);
        end

        // Compare against the post-shift window so the hit lines up with
        // the sample that completes the pattern.
        hit = shift_en
              && (((win_shift ^ pattern) & len_mask) == '0)
              && (hist_inc >= len);

        window_d = window_q;
        hist_d   = hist_q;
        if (clear) begin
            window_d = '0;
            hist_d   = '0;
        end else if (shift_en) begin
            window_d = win_shift;
            hist_d   = (hit && !overlap) ? '0 : hist_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window_q <= '0;
            hist_q   <= '0;
        end else begin
            window_q <= window_d;
            hist_q   <= hist_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence-detector controller.
//   clk, reset        : clock, asynchronous active-high reset
//   cfg_valid/ready   : configuration handshake (ready in IDLE and DONE)
//   cfg_pattern/len   : pattern (bit 0 = most recent) and length
//   cfg_overlap       : allow overlapping matches
//   cfg_target        : match count that ends a run (0 = unlimited)
//   cfg_timeout       : match-free cycles that end a run (0 = disabled)
//   start, abort      : begin a run / return to IDLE
//   d, d_valid        : qualified serial stream
//   match             : one-cycle pulse per detected match
//   match_count       : matches in the current/last run
//   busy, done        : running / run finished
//   timed_out         : run finished by inactivity timeout
//
// state | meaning
// IDLE  | unconfigured or aborted; accepts config
// ARMED | configured, waiting for start
// RUN   | shifting qualified bits, counting matches, timing
// DONE  | run finished; holds count, accepts config or rerun
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAXLEN = SD_MAXLEN,
    parameter int LENW   = SD_LENW,
    parameter int CNTW   = SD_CNTW,
    parameter int TOW    = SD_TOW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LENW-1:0]   cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_target,
    input  logic [TOW-1:0]    cfg_timeout,
    input  logic              start,
    input  logic              abort,
    input  logic              d,
    input  logic              d_valid,
    output logic              match,
    output logic [CNTW-1:0]   match_count,
    output logic              busy,
    output logic              done,
    output logic              timed_out
);

    localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

    state_e            state_q, state_d;
    logic [MAXLEN-1:0] pattern_q, pattern_d;
    logic [LENW-1:0]   len_q, len_d;
    logic              overlap_q, overlap_d;
    logic [CNTW-1:0]   target_q, target_d;
    logic [TOW-1:0]    timeout_q, timeout_d;
    logic [TOW-1:0]    tmr_q, tmr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              match_q, match_d;
    logic              done_q, done_d;
    logic              timed_out_q, timed_out_d;

    logic              cfg_take;
    logic              start_take;
    logic              shift_en;
    logic              core_clear;
    logic              hit;
    logic [LENW-1:0]   len_clamped;
    logic [CNTW-1:0]   count_inc;
    logic [TOW-1:0]    tmr_reload;

    assign cfg_ready  = (state_q == IDLE) || (state_q == DONE);
    assign cfg_take   = cfg_valid && cfg_ready;
    assign start_take = start && ((state_q == ARMED) || (state_q == DONE));
    assign shift_en   = (state_q == RUN) && d_valid;
    assign count_inc  = (count_q == '1) ? count_q : count_q + CNTW'(1);

    // Timer is a down-counter: loaded with timeout-1 and expiring at zero,
    // which equals "timeout cycles in RUN without a match".
    assign tmr_reload = timeout_q - TOW'(1);

    always_comb begin
        if (cfg_len == '0) begin
            len_clamped = LENW'(1);
        end else if (cfg_len > MAXLEN_L) begin
            len_clamped = MAXLEN_L;
        end else begin
            len_clamped = cfg_len;
        end
    end

    seq_match_core #(
        .MAXLEN (MAXLEN),
        .LENW   (LENW)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .clear    (core_clear),
        .d        (d),
        .overlap  (overlap_q),
        .len      (len_q),
        .pattern  (pattern_q),
        .hit      (hit)
    );

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        overlap_d   = overlap_q;
        target_d    = target_q;
        timeout_d   = timeout_q;
        tmr_d       = tmr_q;
        count_d     = count_q;
        match_d     = 1'b0;
        done_d      = done_q;
        timed_out_d = timed_out_q;
        core_clear  = 1'b0;

        if (abort) begin
            // Any hit completing this cycle is dropped along with the run.
            state_d     = IDLE;
            count_d     = '0;
            tmr_d       = '0;
            done_d      = 1'b0;
            timed_out_d = 1'b0;
            core_clear  = 1'b1;
        end else if (cfg_take) begin
            state_d     = ARMED;
            pattern_d   = cfg_pattern;
            len_d       = len_clamped;
            overlap_d   = cfg_overlap;
            target_d    = cfg_target;
            timeout_d   = cfg_timeout;
            count_d     = '0;
            done_d      = 1'b0;
            timed_out_d = 1'b0;
        end else if (start_take) begin
            state_d     = RUN;
            count_d     = '0;
            tmr_d       = tmr_reload;
            done_d      = 1'b0;
            timed_out_d = 1'b0;
            core_clear  = 1'b1;
        end else if (state_q == RUN) begin
            if (hit) begin
                // A hit on the expiry cycle still counts and restarts the timer.
                match_d = 1'b1;
                count_d = count_inc;
                tmr_d   = tmr_reload;
                if ((target_q != '0) && (count_inc == target_q)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end else if ((timeout_q != '0) && (tmr_q == '0)) begin
                state_d     = DONE;
                done_d      = 1'b1;
                timed_out_d = 1'b1;
            end else if (tmr_q != '0) begin
                tmr_d = tmr_q - TOW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            target_q    <= '0;
            timeout_q   <= '0;
            tmr_q       <= '0;
            count_q     <= '0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            overlap_q   <= overlap_d;
            target_q    <= target_d;
            timeout_q   <= timeout_d;
            tmr_q       <= tmr_d;
            count_q     <= count_d;
            match_q     <= match_d;
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign timed_out   = timed_out_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl. The driver pushes the expected cycle and
// count of every match pulse into a queue; a monitor pops and compares on
// each pulse and flags pulses nobody expected.
module tb_seq_det_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_pattern = '0;
    logic [3:0]  cfg_len = '0;
    logic        cfg_overlap = 1'b0;
    logic [7:0]  cfg_target = '0;
    logic [15:0] cfg_timeout = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        d = 1'b0;
    logic        d_valid = 1'b0;
    logic        match;
    logic [7:0]  match_count;
    logic        busy;
    logic        done;
    logic        timed_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int at_cyc;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    seq_det_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .cfg_timeout (cfg_timeout),
        .start       (start),
        .abort       (abort),
        .d           (d),
        .d_valid     (d_valid),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (!reset && match) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_match: pulse at cycle %0d count %0d, none expected", cyc, match_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.at_cyc != cyc || e.cnt != int'(match_count)) begin
                    n_fail++;
                    $display("FAIL match_pulse: got cycle %0d count %0d, expected cycle %0d count %0d",
                             cyc, match_count, e.at_cyc, e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic dd, input logic ab, input logic st);
        @(negedge clk);
        d_valid   = dv;
        d         = dd;
        abort     = ab;
        start     = st;
        cfg_valid = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bit_in(input logic b, input bit exp_hit, input int exp_cnt);
        drive(1'b1, b, 1'b0, 1'b0);
        if (exp_hit) exp_q.push_back('{cyc + 1, exp_cnt});
    endtask

    task automatic gap(input logic b);
        drive(1'b0, b, 1'b0, 1'b0);
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                          input logic [7:0] tgt, input logic [15:0] to);
        @(negedge clk);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_target  = tgt;
        cfg_timeout = to;
        cfg_valid   = 1'b1;
        d_valid     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic do_start();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_abort();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drained(input string name);
        idle();
        idle();
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_done(output int at);
        at = -1000;
        for (int k = 0; k < 60; k++) begin
            idle();
            if (done) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_run;
        int at;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", match_count, 0);
        reset = 1'b0;
        idle();
        chk("post_rst_cfg_ready", cfg_ready, 1);
        chk("post_rst_timed_out", timed_out, 0);

        // Overlap off: 1,0,1,0,1 on 101 -> one match after bit 3
        do_cfg(8'b101, 4'd3, 1'b0, 8'd0, 16'd0);
        idle();
        chk("armed_cfg_ready", cfg_ready, 0);
        chk("armed_busy", busy, 0);
        do_start();
        bit_in(1'b1, 0, 0);
        bit_in(1'b0, 0, 0);
        bit_in(1'b1, 1, 1);
        bit_in(1'b0, 0, 0);
        bit_in(1'b1, 0, 0);
        drained("ovl_off_drained");
        chk("ovl_off_count", match_count, 1);
        chk("run_busy", busy, 1);

        // Config offer during RUN is refused
        chk("run_cfg_ready", cfg_ready, 0);
        do_cfg(8'hFF, 4'd1, 1'b1, 8'd1, 16'd1);
        idle();
        chk("run_cfg_ignored_busy", busy, 1);
        chk("run_cfg_ignored_count", match_count, 1);

        // Overlap on: same stream -> matches after bits 3 and 5
        do_abort();
        idle();
        chk("abort_busy", busy, 0);
        chk("abort_count", match_count, 0);
        chk("abort_cfg_ready", cfg_ready, 1);
        do_cfg(8'b101, 4'd3, 1'b1, 8'd0, 16'd0);
        do_start();
        bit_in(1'b1, 0, 0);
        bit_in(1'b0, 0, 0);
        bit_in(1'b1, 1, 1);
        bit_in(1'b0, 0, 0);
        bit_in(1'b1, 1, 2);
        drained("ovl_on_drained");
        chk("ovl_on_count", match_count, 2);

        // Target stop: 11, target 3, five 1s
        do_abort();
        do_cfg(8'b11, 4'd2, 1'b1, 8'd3, 16'd0);
        do_start();
        bit_in(1'b1, 0, 0);
        bit_in(1'b1, 1, 1);
        bit_in(1'b1, 1, 2);
        bit_in(1'b1, 1, 3);
        bit_in(1'b1, 0, 0);
        drained("target_drained");
        chk("target_done", done, 1);
        chk("target_timed_out", timed_out, 0);
        chk("target_busy", busy, 0);
        chk("target_count", match_count, 3);
        chk("done_cfg_ready", cfg_ready, 1);

        // Timeout 10 with no data: done exactly 10 cycles after RUN entry
        do_cfg(8'b1111, 4'd4, 1'b0, 8'd0, 16'd10);
        idle();
        chk("cfg_from_done_clears_done", done, 0);
        do_start();
        s_run = cyc + 1;
        wait_done(at);
        chk("timeout_latency", at - s_run, 10);
        chk("timeout_flag", timed_out, 1);
        chk("timeout_busy", busy, 0);

        // Rerun; match lands on the expiry cycle and restarts the window
        do_start();
        s_run = cyc + 1;
        repeat (6) idle();
        bit_in(1'b1, 0, 0);
        bit_in(1'b1, 0, 0);
        bit_in(1'b1, 0, 0);
        bit_in(1'b1, 1, 1);
        wait_done(at);
        chk("timeout_restart_latency", at - s_run, 20);
        chk("timeout_restart_flag", timed_out, 1);
        chk("timeout_restart_count", match_count, 1);
        drained("timeout_drained");

        // d_valid gaps (with d toggling) inside a pattern
        do_cfg(8'b101, 4'd3, 1'b0, 8'd0, 16'd0);
        do_start();
        bit_in(1'b1, 0, 0);
        gap(1'b1);
        gap(1'b1);
        bit_in(1'b0, 0, 0);
        gap(1'b1);
        bit_in(1'b1, 1, 1);
        drained("gap_drained");
        chk("gap_count", match_count, 1);

        // cfg_len 0 behaves as length 1
        do_abort();
        do_cfg(8'h01, 4'd0, 1'b1, 8'd0, 16'd0);
        do_start();
        bit_in(1'b1, 1, 1);
        bit_in(1'b0, 0, 0);
        bit_in(1'b1, 1, 2);
        drained("len0_drained");
        chk("len0_count", match_count, 2);

        // cfg_len 15 clamps to 8
        do_abort();
        do_cfg(8'hA5, 4'd15, 1'b0, 8'd0, 16'd0);
        do_start();
        bit_in(1'b0, 0, 0);
        bit_in(1'b1, 0, 0);
        bit_in(1'b0, 0, 0);
        bit_in(1'b1, 0, 0);
        bit_in(1'b0, 0, 0);
        bit_in(1'b0, 0, 0);
        bit_in(1'b1, 0, 0);
        bit_in(1'b0, 0, 0);
        bit_in(1'b1, 1, 1);
        drained("len15_drained");
        chk("len15_count", match_count, 1);

        // Abort on the cycle a match completes: no pulse, count 0
        do_abort();
        do_cfg(8'b11, 4'd2, 1'b1, 8'd0, 16'd0);
        do_start();
        bit_in(1'b1, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drained("abort_match_drained");
        chk("abort_match_count", match_count, 0);
        chk("abort_match_busy", busy, 0);
        chk("abort_match_done", done, 0);

        // Async reset while a match pulse is showing
        do_cfg(8'b11, 4'd2, 1'b1, 8'd0, 16'd0);
        do_start();
        bit_in(1'b1, 0, 0);
        bit_in(1'b1, 1, 1);
        bit_in(1'b1, 1, 2);
        idle();
        #2 reset = 1'b1;
        #1;
        chk("arst_match", match, 0);
        chk("arst_count", match_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        drained("final_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
